score_counter_bank: RTL and testbench

//  Parametrised multi-digit BCD score counter driving NUM_DIGITS active-low 7-seg displays.

---
 rtl/score_counter_bank.sv | 144 ++++++++++++++
 tb/tb_score_counter_bank.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/score_counter_bank.sv
// Multi-digit BCD score counter with wrap/saturate, best-score capture and
// active-low 7-segment outputs with optional leading-zero blanking.

module bcd_seg7 (
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = 7'b1111111;
        if (!blank_i) begin
            case (digit_i)
                4'd0: seg_o = 7'b1000000;
                4'd1: seg_o = 7'b1111001;
                4'd2: seg_o = 7'b0100100;
                4'd3: seg_o = 7'b0110000;
                4'd4: seg_o = 7'b0011001;
                4'd5: seg_o = 7'b0010010;
                4'd6: seg_o = 7'b0000010;
                4'd7: seg_o = 7'b1111000;
                4'd8: seg_o = 7'b0000000;
                4'd9: seg_o = 7'b0010000;
                default: seg_o = 7'b1111111;
            endcase
        end
    end
endmodule

module score_counter_bank #(
    parameter int NUM_DIGITS    = 3,
    parameter int SATURATE      = 0,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ongoing,
    input  logic                    inc,
    input  logic                    dec,
    input  logic                    show_best,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic [4*NUM_DIGITS-1:0] best_bcd,
    output logic                    overflow,
    output logic                    underflow
);
    logic [NUM_DIGITS-1:0][3:0] score_q, score_d;
    logic [NUM_DIGITS-1:0][3:0] best_q, best_d;
    logic                       ongoing_q;
    logic                       ovf_q, ovf_d, unf_q, unf_d;

    logic [NUM_DIGITS-1:0][3:0] inc_val, dec_val, sel;
    logic                       at_max, at_min;
    logic [NUM_DIGITS-1:0]      blank;
    logic [NUM_DIGITS-1:0][6:0] hex_w;

    // Ripple carry/borrow: a digit changes only while every lower digit rolled over.
    always_comb begin
        logic carry, borrow;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            inc_val[i] = score_q[i];
            dec_val[i] = score_q[i];
            if (carry) begin
                if (score_q[i] == 4'd9) inc_val[i] = 4'd0;
                else begin
                    inc_val[i] = score_q[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
            if (borrow) begin
                if (score_q[i] == 4'd0) dec_val[i] = 4'd9;
                else begin
                    dec_val[i] = score_q[i] - 4'd1;
                    borrow     = 1'b0;
                end
            end
        end
        at_max = carry;
        at_min = borrow;
    end

    always_comb begin
        score_d = score_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (!ongoing) begin
            score_d = '0;
        end else if (inc && !dec) begin
            ovf_d = at_max;
            if (!(at_max && SATURATE != 0)) score_d = inc_val;
        end else if (dec && !inc) begin
            unf_d = at_min;
            if (!(at_min && SATURATE != 0)) score_d = dec_val;
        end
    end

    // Packed BCD digits order the same as the decimal value, so a vector compare suffices.
    always_comb begin
        best_d = best_q;
        if (ongoing_q && !ongoing && (score_q > best_q)) best_d = score_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score_q   <= '0;
            best_q    <= '0;
            ongoing_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            score_q   <= score_d;
            best_q    <= best_d;
            ongoing_q <= ongoing;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign sel = show_best ? best_q : score_q;

    always_comb begin
        logic z;
        z = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            z        = z && (sel[i] == 4'd0);
            blank[i] = (BLANK_LEADING != 0) && (i != 0) && z;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_seg7 u_seg (
            .digit_i (sel[g]),
            .blank_i (blank[g]),
            .seg_o   (hex_w[g])
        );
    end

    assign HEX       = hex_w;
    assign score_bcd = score_q;
    assign best_bcd  = best_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_score_counter_bank.sv
// Directed bench: three instances (wrap, saturate, wrap without blanking) share stimulus.

module tb_score_counter_bank;
    localparam int ND = 3;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001, S7 = 7'b1111000, S9 = 7'b0010000;

    logic clk = 1'b0;
    logic reset, ongoing, inc, dec, show_best;
    logic [7*ND-1:0] hex0, hex1, hex2;
    logic [4*ND-1:0] sc0, sc1, sc2, bs0, bs1, bs2;
    logic ovf0, ovf1, ovf2, unf0, unf1, unf2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    score_counter_bank #(.NUM_DIGITS(ND), .SATURATE(0), .BLANK_LEADING(1)) u_wrap (
        .clk(clk), .reset(reset), .ongoing(ongoing), .inc(inc), .dec(dec), .show_best(show_best),
        .HEX(hex0), .score_bcd(sc0), .best_bcd(bs0), .overflow(ovf0), .underflow(unf0));
    score_counter_bank #(.NUM_DIGITS(ND), .SATURATE(1), .BLANK_LEADING(1)) u_sat (
        .clk(clk), .reset(reset), .ongoing(ongoing), .inc(inc), .dec(dec), .show_best(show_best),
        .HEX(hex1), .score_bcd(sc1), .best_bcd(bs1), .overflow(ovf1), .underflow(unf1));
    score_counter_bank #(.NUM_DIGITS(ND), .SATURATE(0), .BLANK_LEADING(0)) u_noblank (
        .clk(clk), .reset(reset), .ongoing(ongoing), .inc(inc), .dec(dec), .show_best(show_best),
        .HEX(hex2), .score_bcd(sc2), .best_bcd(bs2), .overflow(ovf2), .underflow(unf2));

    typedef struct {
        logic        o, i, d, s;
        int          rep;
        logic [11:0] score;
        logic [11:0] best;
        logic        chk_hex;
        logic [20:0] hex;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic o, input logic i, input logic d, input logic s, input int n);
        repeat (n) begin
            ongoing = o; inc = i; dec = d; show_best = s;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_flags(input string nm, input logic [3:0] exp);
        chk({nm, "_flags_wrap"}, {30'd0, ovf0, unf0}, {30'd0, exp[3:2]});
        chk({nm, "_flags_sat"},  {30'd0, ovf1, unf1}, {30'd0, exp[1:0]});
    endtask

    initial begin
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,  1, 12'h000, 12'h012, 1'b0, 21'd0};
        tbl[1]  = '{1'b1,1'b1,1'b0,1'b0, 42, 12'h042, 12'h012, 1'b0, 21'd0};
        tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,  1, 12'h042, 12'h012, 1'b1, {SB,S4,S2}};
        tbl[3]  = '{1'b1,1'b0,1'b1,1'b0,  1, 12'h041, 12'h012, 1'b0, 21'd0};
        tbl[4]  = '{1'b1,1'b1,1'b0,1'b0,  1, 12'h042, 12'h012, 1'b0, 21'd0};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,  1, 12'h000, 12'h042, 1'b0, 21'd0};
        tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,  1, 12'h000, 12'h042, 1'b1, {SB,SB,S0}};
        tbl[7]  = '{1'b1,1'b1,1'b0,1'b0, 17, 12'h017, 12'h042, 1'b1, {SB,S1,S7}};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,  1, 12'h000, 12'h042, 1'b0, 21'd0};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,  1, 12'h000, 12'h042, 1'b1, {SB,S4,S2}};
        tbl[10] = '{1'b1,1'b1,1'b0,1'b0,100, 12'h100, 12'h042, 1'b1, {S1,S0,S0}};
        tbl[11] = '{1'b1,1'b0,1'b1,1'b0,  1, 12'h099, 12'h042, 1'b1, {SB,S9,S9}};
        tbl[12] = '{1'b1,1'b1,1'b1,1'b0,  1, 12'h099, 12'h042, 1'b0, 21'd0};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b0,  1, 12'h000, 12'h099, 1'b0, 21'd0};

        reset = 1'b1; ongoing = 1'b0; inc = 1'b0; dec = 1'b0; show_best = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_score", sc0, 12'h000);
        chk("rst_best", bs1, 12'h000);
        chk_flags("rst", 4'b0000);
        chk("rst_hex_blank", hex0, {SB,SB,S0});
        chk("rst_hex_noblank", hex2, {S0,S0,S0});
        reset = 1'b0;

        step(1'b1, 1'b1, 1'b0, 1'b0, 12);
        chk("t1_score", sc0, 12'h012);
        chk("t1_hex", hex0, {SB,S1,S2});
        chk("t1_hex_noblank", hex2, {S0,S1,S2});

        for (int k = 0; k < 14; k++) begin
            step(tbl[k].o, tbl[k].i, tbl[k].d, tbl[k].s, tbl[k].rep);
            chk($sformatf("tbl%0d_score_wrap", k), sc0, tbl[k].score);
            chk($sformatf("tbl%0d_score_sat", k), sc1, tbl[k].score);
            chk($sformatf("tbl%0d_best", k), bs0, tbl[k].best);
            chk_flags($sformatf("tbl%0d", k), 4'b0000);
            if (tbl[k].chk_hex) chk($sformatf("tbl%0d_hex", k), hex0, tbl[k].hex);
        end

        // Overflow at 999: wrap to 000 vs hold, both pulse one cycle.
        step(1'b1, 1'b1, 1'b0, 1'b0, 998);
        chk("t2_998", sc1, 12'h998);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1);
        chk("t2_999_wrap", sc0, 12'h999);
        chk_flags("t2_999", 4'b0000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1);
        chk("t2_ovf_wrap_score", sc0, 12'h000);
        chk("t2_ovf_sat_score", sc1, 12'h999);
        chk_flags("t2_ovf", 4'b1010);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1);
        chk_flags("t2_after", 4'b0000);
        chk("t2_hold_sat", sc1, 12'h999);

        // Round end: wrap instance at 000 keeps best 099, saturate instance captures 999.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1);
        chk("t3_best_wrap", bs0, 12'h099);
        chk("t3_best_sat", bs1, 12'h999);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1);
        chk("t3_unf_wrap_score", sc0, 12'h999);
        chk("t3_unf_sat_score", sc1, 12'h000);
        chk_flags("t3_unf", 4'b0101);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1);
        chk_flags("t3_after", 4'b0000);

        // Mid-round reset with a strobe pending.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 123);
        chk("t6_pre", sc1, 12'h123);
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1);
        reset = 1'b0;
        chk("t6_score", sc0, 12'h000);
        chk("t6_best_wrap", bs0, 12'h000);
        chk("t6_best_sat", bs1, 12'h000);
        chk("t6_hex", hex0, {SB,SB,S0});
        step(1'b1, 1'b0, 1'b0, 1'b0, 1);
        chk_flags("t6_next", 4'b0000);
        chk("t6_next_score", sc1, 12'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
